bus_wr_master: RTL and testbench

- Master-side write port that sits directly upstream of the bus arbiter; one instance per master.
- Queues core write requests in a small FIFO.
- Raises bus_req while work is pending, and bus_lock to keep ownership for short bursts.
- On grant, presents one queued addr/wd/we beat per cycle to the arbiter's per-master inputs.

---
 rtl/bus_wr_master.sv | 172 +++++++++++++++++
 tb/tb_bus_wr_master.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_wr_master.sv
// Master-side write port: queues core writes and presents them, one beat per granted cycle, to the bus arbiter.
// Optional statistics counters (xfer_cnt, wait_cnt) are enabled by defining BUS_WR_MASTER_STAT_EN.
module bus_wr_master #(
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wd,
    input  logic        in_we,
    output logic        bus_req,
    output logic        bus_lock,
    input  logic        bus_grant,
    output logic [31:0] addr_m,
    output logic [31:0] wd_m,
    output logic        we_m,
    output logic        busy
`ifdef BUS_WR_MASTER_STAT_EN
    ,
    output logic [31:0] xfer_cnt,
    output logic [31:0] wait_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    // Entry layout: {we, addr, wd}
    logic [64:0]   fifo_mem [DEPTH];
    logic [64:0]   head;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;

    logic push;
    logic xfer;
    logic active;

    always_comb begin
        active   = (state_q != ST_IDLE);
        in_ready = (count_q != FULL);
        push     = in_valid && in_ready;
        xfer     = active && bus_grant && (count_q != '0);
        head     = fifo_mem[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (xfer) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !xfer) begin
            count_d = count_q + CW'(1);
        end else if (!push && xfer) begin
            count_d = count_q - CW'(1);
        end
    end

    // A beat taken straight from REQ obeys the same exit rules as one taken in XFER,
    // so a lone entry or a one-beat burst releases the bus immediately.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            ST_IDLE: begin
                burst_d = '0;
                if (count_q != '0) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ, ST_XFER: begin
                if (xfer) begin
                    if (((count_q == CW'(1)) && !push) || (burst_q == LAST_BEAT)) begin
                        state_d = ST_IDLE;
                        burst_d = '0;
                    end else begin
                        state_d = ST_XFER;
                        burst_d = burst_q + BW'(1);
                    end
                end else if (state_q == ST_XFER) begin
                    state_d = ST_REQ;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                burst_d = '0;
            end
        endcase
    end

    always_comb begin
        bus_req  = active;
        bus_lock = active && (count_q >= CW'(2)) && (burst_q < LAST_BEAT);
        busy     = (count_q != '0) || active;
        addr_m   = xfer ? head[63:32] : 32'd0;
        wd_m     = xfer ? head[31:0]  : 32'd0;
        we_m     = xfer ? head[64]    : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            burst_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            burst_q  <= burst_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_we, in_addr, in_wd};
        end
    end

`ifdef BUS_WR_MASTER_STAT_EN
    logic [31:0] xfer_cnt_q, xfer_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    // xfer_cnt wraps naturally; wait_cnt sticks at all-ones.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        wait_cnt_d = wait_cnt_q;
        if (xfer) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
        end
        if ((state_q == ST_REQ) && !bus_grant && (wait_cnt_q != 32'hFFFF_FFFF)) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
    assign wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_bus_wr_master.sv
// Directed bench for bus_wr_master: a queue-based reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_bus_wr_master;

    localparam int DEPTH = 4;
    localparam int MAXB  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_we = 1'b0;
    logic        bus_grant = 1'b0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wd = '0;
    logic        in_ready, bus_req, bus_lock, we_m, busy;
    logic [31:0] addr_m, wd_m;
`ifdef BUS_WR_MASTER_STAT_EN
    logic [31:0] xfer_cnt, wait_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] seen_addr[$];
    logic        seen_lock[$];

    logic [64:0] mq[$];
    int          mphase = 0;
    int          mbeats = 0;
    bit          mvalid = 1'b0;

    bus_wr_master #(.DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_wd    (in_wd),
        .in_we    (in_we),
        .bus_req  (bus_req),
        .bus_lock (bus_lock),
        .bus_grant(bus_grant),
        .addr_m   (addr_m),
        .wd_m     (wd_m),
        .we_m     (we_m),
        .busy     (busy)
`ifdef BUS_WR_MASTER_STAT_EN
        ,
        .xfer_cnt (xfer_cnt),
        .wait_cnt (wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a plain queue of pending writes plus an ownership phase
    // (0 = not requesting, 1 = requesting, 2 = owning) and beats taken this ownership.
    initial begin : model
        int          cnt;
        bit          x, pm, rdy, lk;
        logic [64:0] h;
        forever begin
            @(negedge clk);
            cnt = mq.size();
            rdy = (cnt != DEPTH);
            x   = (mphase != 0) && bus_grant && (cnt != 0);
            h   = (cnt != 0) ? mq[0] : 65'd0;
            lk  = (mphase != 0) && (cnt >= 2) && (mbeats < MAXB - 1);
            if (mvalid) begin
                chk("cyc_in_ready", 32'(in_ready), 32'(rdy));
                chk("cyc_bus_req",  32'(bus_req),  32'(mphase != 0));
                chk("cyc_bus_lock", 32'(bus_lock), 32'(lk));
                chk("cyc_busy",     32'(busy),     32'((cnt != 0) || (mphase != 0)));
                chk("cyc_addr_m",   addr_m,        x ? h[63:32] : 32'd0);
                chk("cyc_wd_m",     wd_m,          x ? h[31:0]  : 32'd0);
                chk("cyc_we_m",     32'(we_m),     32'(x ? h[64] : 1'b0));
                if (we_m === 1'b1) begin
                    seen_addr.push_back(addr_m);
                    seen_lock.push_back(bus_lock);
                end
            end
            if (rst) begin
                mq.delete();
                mphase = 0;
                mbeats = 0;
                mvalid = 1'b1;
            end else if (mvalid) begin
                pm = in_valid && rdy;
                if (mphase == 0) begin
                    mbeats = 0;
                    if (cnt != 0) mphase = 1;
                end else if (x) begin
                    h = mq.pop_front();
                    if (((cnt == 1) && !pm) || (mbeats + 1 == MAXB)) begin
                        mphase = 0;
                        mbeats = 0;
                    end else begin
                        mphase = 2;
                        mbeats++;
                    end
                end else if (mphase == 2) begin
                    mphase = 1;
                    mbeats = 0;
                end
                if (pm) mq.push_back({in_we, in_addr, in_wd});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] a, input logic [31:0] d);
        bit acc;
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_wd    = d;
        in_we    = 1'b1;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic check_seen(input string nm, input int n, input logic [31:0] base);
        chk({nm, "_beats"}, 32'(seen_addr.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            chk({nm, "_order"}, (i < seen_addr.size()) ? seen_addr[i] : 32'hFFFF_FFFF,
                base + 32'(4 * i));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit exp_lock [6];
        exp_lock = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_bus_req",  32'(bus_req),  32'd0);
        chk("rst_bus_lock", 32'(bus_lock), 32'd0);
        chk("rst_we_m",     32'(we_m),     32'd0);
        chk("rst_addr_m",   addr_m,        32'd0);
        chk("rst_wd_m",     wd_m,          32'd0);
        chk("rst_busy",     32'(busy),     32'd0);

        // Single write with grant held high
        seen_addr.delete(); seen_lock.delete();
        bus_grant = 1'b1;
        in_valid = 1'b1; in_addr = 32'h100; in_wd = 32'hDEAD_BEEF; in_we = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        chk("t1_c0_req",  32'(bus_req), 32'd0);
        chk("t1_c0_busy", 32'(busy),    32'd1);
        tick(); #1;
        chk("t1_c1_req",  32'(bus_req), 32'd1);
        chk("t1_c1_addr", addr_m,       32'h100);
        chk("t1_c1_wd",   wd_m,         32'hDEAD_BEEF);
        chk("t1_c1_we",   32'(we_m),    32'd1);
        tick(); #1;
        chk("t1_c2_req",  32'(bus_req), 32'd0);
        chk("t1_c2_busy", 32'(busy),    32'd0);
        chk("t1_c2_we",   32'(we_m),    32'd0);
        check_seen("t1", 1, 32'h100);

        // Fill the FIFO with grant low; the fifth request waits
        seen_addr.delete(); seen_lock.delete();
        bus_grant = 1'b0;
        for (int i = 0; i < 4; i++) send_one(32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
        in_valid = 1'b1; in_addr = 32'h210; in_wd = 32'h1004;
        #1;
        chk("t2_full_ready", 32'(in_ready), 32'd0);
        chk("t2_full_req",   32'(bus_req),  32'd1);
        tick(); tick(); #1;
        chk("t2_held_ready", 32'(in_ready), 32'd0);
        chk("t2_held_we",    32'(we_m),     32'd0);
        bus_grant = 1'b1;
        send_one(32'h210, 32'h1004);
        in_valid = 1'b0;
        wait_idle();
        check_seen("t2", 5, 32'h200);

        // Burst limit: six beats split 4 + 2 with a one-cycle release between
        seen_addr.delete(); seen_lock.delete();
        bus_grant = 1'b0;
        for (int i = 0; i < 4; i++) send_one(32'h300 + 32'(4 * i), 32'h2000 + 32'(i));
        bus_grant = 1'b1;
        send_one(32'h310, 32'h2004);
        send_one(32'h314, 32'h2005);
        in_valid = 1'b0;
        wait_idle();
        check_seen("t3", 6, 32'h300);
        for (int i = 0; i < 6; i++) begin
            chk("t3_lock", (i < seen_lock.size()) ? 32'(seen_lock[i]) : 32'hFFFF_FFFF,
                32'(exp_lock[i]));
        end

        // Grant lost after two beats, then restored
        seen_addr.delete(); seen_lock.delete();
        bus_grant = 1'b0;
        for (int i = 0; i < 4; i++) send_one(32'h400 + 32'(4 * i), 32'h3000 + 32'(i));
        in_valid = 1'b0;
        bus_grant = 1'b1;
        tick(); tick();
        bus_grant = 1'b0;
        #1;
        chk("t4_lost_we",   32'(we_m),    32'd0);
        chk("t4_lost_addr", addr_m,       32'd0);
        chk("t4_lost_req",  32'(bus_req), 32'd1);
        tick(); tick(); #1;
        chk("t4_wait_req",   32'(bus_req),          32'd1);
        chk("t4_wait_beats", 32'(seen_addr.size()), 32'd2);
        bus_grant = 1'b1;
        wait_idle();
        check_seen("t4", 4, 32'h400);

        // Reset while owning the bus with three entries still queued
        seen_addr.delete(); seen_lock.delete();
        bus_grant = 1'b0;
        for (int i = 0; i < 4; i++) send_one(32'h500 + 32'(4 * i), 32'h4000 + 32'(i));
        in_valid = 1'b0;
        bus_grant = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t5_req",   32'(bus_req),  32'd0);
        chk("t5_lock",  32'(bus_lock), 32'd0);
        chk("t5_we",    32'(we_m),     32'd0);
        chk("t5_ready", 32'(in_ready), 32'd1);
        chk("t5_busy",  32'(busy),     32'd0);
        repeat (5) tick();
        check_seen("t5", 2, 32'h500);

        // Push and pop together while one entry is queued
        seen_addr.delete(); seen_lock.delete();
        bus_grant = 1'b1;
        in_valid = 1'b1; in_addr = 32'h600; in_wd = 32'h5000; in_we = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_addr = 32'h604; in_wd = 32'h5001;
        #1;
        chk("t6_c0_addr", addr_m,        32'h600);
        chk("t6_c0_lock", 32'(bus_lock), 32'd0);
        tick();
        in_valid = 1'b1; in_addr = 32'h608; in_wd = 32'h5002;
        #1;
        chk("t6_c1_req",   32'(bus_req),  32'd1);
        chk("t6_c1_addr",  addr_m,        32'h604);
        chk("t6_c1_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t6_c2_req",  32'(bus_req), 32'd1);
        chk("t6_c2_addr", addr_m,       32'h608);
        chk("t6_c2_busy", 32'(busy),    32'd1);
        tick(); #1;
        chk("t6_c3_req",  32'(bus_req), 32'd0);
        chk("t6_c3_busy", 32'(busy),    32'd0);
        check_seen("t6", 3, 32'h600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
